seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive identical synchronized samples required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYCLES, default 2097152: clk cycles allowed without a completed frame before stale asserts.
REQ-003 clk  input  1  system clock; all state rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 anode  input  4  active-low digit select; 0111=D0 (tens A), 1011=D1 (ones A), 1101=D2 (tens B), 1110=D3 (ones B).
REQ-006 display  input  7  active-low cathodes, team segment table (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100).
REQ-007 sec  output  6  value recovered from D0/D1.
REQ-008 sec1  output  6  value recovered from D2/D3.
REQ-009 frame_valid  output  1  one-cycle pulse when sec/sec1 update.
REQ-010 pattern_err  output  1  one-cycle pulse on capture of a cathode pattern not in the table.
REQ-011 range_err  output  1  one-cycle pulse when a completed frame yields a value above 63.
REQ-012 stale  output  1  level; no frame completed within TIMEOUT_CYCLES.

Function
REQ-013 anode and display SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Stability counter SHALL reset whenever synchronized {anode,display} differs from the previous sample, and increment (saturating) otherwise.
REQ-015 Capture SHALL occur on the cycle the counter reaches SETTLE_CYCLES-1 while anode is exactly one of the four one-hot-low codes; exactly one capture per dwell.
REQ-016 anode 1111 or any multi-low code SHALL never capture and SHALL clear the per-dwell captured flag.
REQ-017 Capture with a valid pattern SHALL store the 4-bit BCD in that digit's slot and set its seen bit; a repeat capture overwrites the slot.
REQ-018 Capture with an invalid pattern SHALL pulse pattern_err, leave slot and seen bit unchanged.
REQ-019 State machine: COLLECT (accumulating seen bits) -> ASSEMBLE (entered the cycle after all four seen bits are set) -> COLLECT next cycle.
REQ-020 In ASSEMBLE: valA = D0*10+D1, valB = D2*10+D3 computed at 7 bits; if both <=63, sec/sec1 load and frame_valid pulses that same cycle.
REQ-021 In ASSEMBLE with either value >63: range_err pulses, sec/sec1 hold, frame_valid stays low.
REQ-022 Leaving ASSEMBLE SHALL clear all seen bits; slots retain contents.
REQ-023 A capture coinciding with ASSEMBLE SHALL be applied after the clear (counts toward the next frame).
REQ-024 Timeout counter SHALL restart on frame_valid and on reset; stale sets when it reaches TIMEOUT_CYCLES and clears on the next frame_valid.
REQ-025 Latency: input edge to capture = 2 + SETTLE_CYCLES cycles; last capture to frame_valid = 1 cycle.

Reset
REQ-026 On rst: sec=0, sec1=0, frame_valid=0, pattern_err=0, range_err=0, stale=0, slots=0, seen=0, counters=0, state=COLLECT, synchronizers=all-ones.
REQ-027 rst asserted mid-frame SHALL discard partial frame; no frame_valid until four fresh captures after release.

Configuration
REQ-028 Macro SEG_SCAN_ERR_COUNT_EN defined: adds output err_count (8 bits), saturating at 255, incremented by each pattern_err or range_err pulse (both in one cycle counts 1), reset to 0.
REQ-029 Macro undefined: err_count port and counter absent; all other behaviour identical.

Structure
REQ-030 Shared package seg_pkg SHALL hold cathode pattern constants, anode digit codes, and digit index typedef; the existing display driver uses the same package.
REQ-031 Combinational sub-module seg_pattern_decode SHALL map 7-bit pattern to {valid, bcd[3:0]}.

Verification
REQ-032 Driver-style scan of sec=42, sec1=7 (digits 4,2,0,7), dwell 16 cycles -> frame_valid pulse, sec=42, sec1=7.
REQ-033 D2 pattern 1111111 inside scan -> pattern_err pulse, no frame_valid until valid D2 captured.
REQ-034 Digits 9,9,0,1 -> range_err pulse, sec/sec1 hold prior values 42/7.
REQ-035 Glitch: anode 1011 for 2 cycles with SETTLE_CYCLES=4 -> no capture; anode 1001 held 20 cycles -> no capture.
REQ-036 rst after three captures, then full scan 1,5,3,0 -> single frame_valid, sec=15, sec1=30.
REQ-037 TIMEOUT_CYCLES=100, no scan -> stale=1 at cycle 100; valid frame -> stale=0 with frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and types
// Cathode patterns are active-low {a,b,c,d,e,f,g}; anode codes are active-low one-hot.
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;

   localparam logic [3:0] ANODE_D0 = 4'b0111;
   localparam logic [3:0] ANODE_D1 = 4'b1011;
   localparam logic [3:0] ANODE_D2 = 4'b1101;
   localparam logic [3:0] ANODE_D3 = 4'b1110;

   typedef enum logic [1:0] {
      DIG_D0 = 2'd0,
      DIG_D1 = 2'd1,
      DIG_D2 = 2'd2,
      DIG_D3 = 2'd3
   } digit_idx_t;

   typedef enum logic {
      ST_COLLECT  = 1'b0,
      ST_ASSEMBLE = 1'b1
   } scan_state_t;

   typedef struct packed {
      logic       valid;
      digit_idx_t idx;
   } anode_dec_t;

   function automatic anode_dec_t anode_decode(input logic [3:0] anode);
      anode_dec_t r;
      r.valid = 1'b1;
      r.idx   = DIG_D0;
      case (anode)
         ANODE_D0: r.idx = DIG_D0;
         ANODE_D1: r.idx = DIG_D1;
         ANODE_D2: r.idx = DIG_D2;
         ANODE_D3: r.idx = DIG_D3;
         default:  r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scan input and decoded result bundle
// SEG_SCAN_ERR_COUNT_EN adds the err_count signal.
interface seg_scan_decoder_if;
   logic [3:0] anode;
   logic [6:0] display;
   logic [5:0] sec;
   logic [5:0] sec1;
   logic       frame_valid;
   logic       pattern_err;
   logic       range_err;
   logic       stale;
`ifdef SEG_SCAN_ERR_COUNT_EN
   logic [7:0] err_count;

   modport master (output anode, output display,
                   input sec, input sec1, input frame_valid, input pattern_err,
                   input range_err, input stale, input err_count);
   modport slave  (input anode, input display,
                   output sec, output sec1, output frame_valid, output pattern_err,
                   output range_err, output stale, output err_count);
`else
   modport master (output anode, output display,
                   input sec, input sec1, input frame_valid, input pattern_err,
                   input range_err, input stale);
   modport slave  (input anode, input display,
                   output sec, output sec1, output frame_valid, output pattern_err,
                   output range_err, output stale);
`endif
endinterface

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - cathode pattern to BCD digit
// Patterns outside the segment table report o_valid=0.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic       o_valid,
   output logic [3:0] o_bcd
);

   always_comb begin
      o_valid = 1'b1;
      o_bcd   = 4'd0;
      case (i_pattern)
         SEG_0:   o_bcd = 4'd0;
         SEG_1:   o_bcd = 4'd1;
         SEG_2:   o_bcd = 4'd2;
         SEG_3:   o_bcd = 4'd3;
         SEG_4:   o_bcd = 4'd4;
         SEG_5:   o_bcd = 4'd5;
         SEG_6:   o_bcd = 4'd6;
         SEG_7:   o_bcd = 4'd7;
         SEG_8:   o_bcd = 4'd8;
         SEG_9:   o_bcd = 4'd9;
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers two 2-digit values from a multiplexed 7-seg scan
// Optional SEG_SCAN_ERR_COUNT_EN adds a saturating error counter on err_count.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 2097152
)(
   input  logic                clk,
   input  logic                rst,
   seg_scan_decoder_if.slave   bus
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   logic [3:0]       r_anode_m, r_anode_s, r_prev_anode;
   logic [6:0]       r_disp_m, r_disp_s, r_prev_disp;
   logic [CW-1:0]    r_stab_cnt;
   logic             r_captured;
   logic [3:0][3:0]  r_slot;
   logic [3:0]       r_seen;
   scan_state_t      r_state;
   logic [5:0]       r_sec, r_sec1;
   logic             r_frame_valid, r_pattern_err, r_range_err, r_stale;
   logic [TW-1:0]    r_to_cnt;

   logic             w_changed;
   logic [CW-1:0]    w_cnt_next;
   anode_dec_t       w_dec;
   logic             w_capture, w_cap_ok, w_cap_bad;
   logic             w_pat_valid;
   logic [3:0]       w_pat_bcd;
   logic [6:0]       w_val_a, w_val_b;
   scan_state_t      w_state_next;
   logic [3:0]       w_seen_next;
   logic             w_frame_load, w_range_hit;

   seg_pattern_decode u_decode (
      .i_pattern (r_disp_s),
      .o_valid   (w_pat_valid),
      .o_bcd     (w_pat_bcd)
   );

   // A dwell starts whenever the synchronized sample changes; capture fires once per dwell.
   assign w_changed  = {r_anode_s, r_disp_s} != {r_prev_anode, r_prev_disp};
   assign w_cnt_next = w_changed ? '0 :
                       (r_stab_cnt == SETTLE_MAX) ? r_stab_cnt : r_stab_cnt + CW'(1);
   assign w_dec      = anode_decode(r_anode_s);
   assign w_capture  = w_dec.valid && (w_cnt_next == SETTLE_MAX) && (w_changed || !r_captured);
   assign w_cap_ok   = w_capture && w_pat_valid;
   assign w_cap_bad  = w_capture && !w_pat_valid;

   assign w_val_a = 7'(r_slot[0]) * 7'd10 + 7'(r_slot[1]);
   assign w_val_b = 7'(r_slot[2]) * 7'd10 + 7'(r_slot[3]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_COLLECT;
      else     r_state <= w_state_next;
   end

   // Frame results are registered on ASSEMBLE entry so they are visible during ASSEMBLE.
   always_comb begin
      w_state_next = r_state;
      w_seen_next  = r_seen;
      w_frame_load = 1'b0;
      w_range_hit  = 1'b0;
      case (r_state)
         ST_COLLECT: begin
            if (r_seen == 4'hF) begin
               w_state_next = ST_ASSEMBLE;
               if (w_val_a <= 7'd63 && w_val_b <= 7'd63) w_frame_load = 1'b1;
               else                                      w_range_hit  = 1'b1;
            end
         end
         ST_ASSEMBLE: begin
            w_state_next = ST_COLLECT;
            w_seen_next  = 4'h0;
         end
         default: w_state_next = ST_COLLECT;
      endcase
      if (w_cap_ok) w_seen_next[w_dec.idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_anode_m     <= 4'hF;
         r_anode_s     <= 4'hF;
         r_prev_anode  <= 4'hF;
         r_disp_m      <= 7'h7F;
         r_disp_s      <= 7'h7F;
         r_prev_disp   <= 7'h7F;
         r_stab_cnt    <= '0;
         r_captured    <= 1'b0;
         r_slot        <= '0;
         r_seen        <= 4'h0;
         r_sec         <= 6'd0;
         r_sec1        <= 6'd0;
         r_frame_valid <= 1'b0;
         r_pattern_err <= 1'b0;
         r_range_err   <= 1'b0;
      end else begin
         r_anode_m     <= bus.anode;
         r_anode_s     <= r_anode_m;
         r_disp_m      <= bus.display;
         r_disp_s      <= r_disp_m;
         r_prev_anode  <= r_anode_s;
         r_prev_disp   <= r_disp_s;
         r_stab_cnt    <= w_cnt_next;
         if (!w_dec.valid)   r_captured <= 1'b0;
         else if (w_capture) r_captured <= 1'b1;
         else if (w_changed) r_captured <= 1'b0;
         if (w_cap_ok) r_slot[w_dec.idx] <= w_pat_bcd;
         r_seen        <= w_seen_next;
         r_frame_valid <= w_frame_load;
         r_range_err   <= w_range_hit;
         r_pattern_err <= w_cap_bad;
         if (w_frame_load) begin
            r_sec  <= w_val_a[5:0];
            r_sec1 <= w_val_b[5:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
         r_stale  <= 1'b0;
      end else if (w_frame_load) begin
         r_to_cnt <= '0;
         r_stale  <= 1'b0;
      end else if (!r_stale) begin
         r_to_cnt <= r_to_cnt + TW'(1);
         if (r_to_cnt == TMO_LAST) r_stale <= 1'b1;
      end
   end

`ifdef SEG_SCAN_ERR_COUNT_EN
   logic [7:0] r_err_count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_err_count <= 8'd0;
      else if ((w_cap_bad || w_range_hit) && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
   end
   assign bus.err_count = r_err_count;
`endif

   assign bus.sec         = r_sec;
   assign bus.sec1        = r_sec1;
   assign bus.frame_valid = r_frame_valid;
   assign bus.pattern_err = r_pattern_err;
   assign bus.range_err   = r_range_err;
   assign bus.stale       = r_stale;

endmodule
